seg7_debug_mux: RTL and testbench

Board-level debug display and CPU-pacing controller for the single-cycle core, replacing the fixed 8-display, 2-channel hex hookup. It time-multiplexes one of N_CH debug words onto a shared-cathode 7-segment bus with per-digit anode strobes, and steps through the channels with a debounced button. It also produces a CPU clock-enable pulse, either free-running or single-stepped, in place of a divided clock.

---
 rtl/seg7_debug_mux.sv | 117 +++++++++++
 tb/tb_seg7_debug_mux.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_debug_mux.sv
// seg7_debug_mux: multiplexed 7-segment debug display with debounced channel select and CPU run/step clock enable
//   clk100MHz  system clock
//   rst        asynchronous active-high reset
//   ch_data    N_CH packed debug words, channel k at [k*DATA_W +: DATA_W]
//   btn_sel    raw button, advances the displayed channel
//   btn_step   raw button, issues one cpu_en pulse in step mode
//   mode_run   raw switch, 1 = free-running cpu_en, 0 = single-step
//   cpu_en     one-cycle CPU clock-enable pulse
//   seg/dp/an  active-low segments (bit0=a), decimal point and one-hot-low digit strobes
//   ch_idx     currently displayed channel
module seg7_debug_mux #(
  parameter int N_CH = 4,
  parameter int DATA_W = 32,
  parameter int N_DIGITS = 8,
  parameter int SCAN_DIV = 100000,
  parameter int DEB_CYCLES = 1000000,
  parameter int RUN_DIV = 5000000,
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk100MHz,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic                     btn_sel,
  input  logic                     btn_step,
  input  logic                     mode_run,
  output logic                     cpu_en,
  output logic [6:0]               seg,
  output logic                     dp,
  output logic [N_DIGITS-1:0]      an,
  output logic [CW-1:0]            ch_idx
);
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int NV = (DATA_W / 4 < N_DIGITS) ? DATA_W / 4 : N_DIGITS;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  // bit 0 = btn_sel path, bit 1 = btn_step path
  logic [1:0] s1, s2, deb, deb_d, press;
  logic [1:0][DBW-1:0] dcnt;
  logic ms1, run;
  logic [SW-1:0] presc;
  logic [DW-1:0] digit;
  logic [RW-1:0] rcnt;
  logic [DATA_W-1:0] word;
  logic [3:0] nib;
  logic blank, scan_tc, run_tc;
  assign scan_tc = presc == SW'(SCAN_DIV - 1);
  assign run_tc = rcnt == RW'(RUN_DIV - 1);
  always_ff @(posedge clk100MHz or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      ms1 <= 1'b0;
      run <= 1'b0;
      deb <= '0;
      deb_d <= '0;
      press <= '0;
      dcnt <= '0;
    end else begin
      s1 <= {btn_step, btn_sel};
      s2 <= s1;
      ms1 <= mode_run;
      run <= ms1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      // the counter only runs while the synchronised input disagrees with the debounced one
      for (int i = 0; i < 2; i++)
        if (s2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DBW'(DEB_CYCLES - 1)) begin
          deb[i] <= s2[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 1'b1;
    end
  always_ff @(posedge clk100MHz or posedge rst)
    if (rst) begin
      presc <= '0;
      digit <= '0;
      ch_idx <= '0;
    end else begin
      presc <= scan_tc ? '0 : presc + 1'b1;
      if (scan_tc) digit <= (digit == DW'(N_DIGITS - 1)) ? '0 : digit + 1'b1;
      if (press[0]) ch_idx <= (ch_idx == CW'(N_CH - 1)) ? '0 : ch_idx + 1'b1;
    end
  // holding the counter at 0 outside run mode makes every mode change restart a full period
  always_ff @(posedge clk100MHz or posedge rst)
    if (rst) begin
      rcnt <= '0;
      cpu_en <= 1'b0;
    end else begin
      rcnt <= (!run || run_tc) ? '0 : rcnt + 1'b1;
      cpu_en <= run ? run_tc : press[1];
    end
  always_comb begin
    word = '0;
    for (int k = 0; k < N_CH; k++) word = (ch_idx == CW'(k)) ? ch_data[k*DATA_W +: DATA_W] : word;
    nib = '0;
    blank = 1'b1;
    for (int k = 0; k < NV; k++)
      if (digit == DW'(k)) begin
        nib = word[k*4 +: 4];
        blank = 1'b0;
      end
  end
  // seg, dp and an share one register stage so the strobe never leads its segment pattern
  always_ff @(posedge clk100MHz or posedge rst)
    if (rst) begin
      seg <= 7'h7F;
      dp <= 1'b1;
      an <= '1;
    end else begin
      seg <= blank ? 7'h7F : GLYPH[nib];
      dp <= 32'(digit) != 32'(ch_idx);
      an <= ~(N_DIGITS'(1) << digit);
    end
endmodule

// File: tb/tb_seg7_debug_mux.sv
// tb_seg7_debug_mux: scoreboard bench for seg7_debug_mux (32-bit and 16-bit channel instances)
module tb_seg7_debug_mux;
  typedef struct {int t; int v;} ev_t;
  typedef struct {int t; logic [7:0] an; logic [6:0] seg; logic dp;} dsp_t;
  localparam logic [6:0] GL [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                     7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                     7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic clk = 1'b0;
  logic rst, btn_sel, btn_step, mode_run;
  logic [127:0] ch_a;
  logic [63:0] ch_b;
  logic cpu_en, dp_a, cpu_en_b, dp_b;
  logic [6:0] seg_a, seg_b;
  logic [7:0] an_a, an_b;
  logic [1:0] ch_idx, ch_idx_b;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int r, c, e, t0;
  bit mon_a = 0;
  bit mon_b = 0;
  ev_t qch[$];
  int qen[$];
  dsp_t qa[$], qb[$];
  logic [15:0] last_a = {8'hFF, 7'h7F, 1'b1};
  logic [15:0] last_b = {8'hFF, 7'h7F, 1'b1};
  logic [1:0] last_ch = 2'd0;

  seg7_debug_mux #(.N_CH(4), .DATA_W(32), .N_DIGITS(8), .SCAN_DIV(4), .DEB_CYCLES(8), .RUN_DIV(10)) dut_a (
    .clk100MHz(clk), .rst(rst), .ch_data(ch_a), .btn_sel(btn_sel), .btn_step(btn_step),
    .mode_run(mode_run), .cpu_en(cpu_en), .seg(seg_a), .dp(dp_a), .an(an_a), .ch_idx(ch_idx));
  seg7_debug_mux #(.N_CH(4), .DATA_W(16), .N_DIGITS(8), .SCAN_DIV(4), .DEB_CYCLES(8), .RUN_DIV(10)) dut_b (
    .clk100MHz(clk), .rst(rst), .ch_data(ch_b), .btn_sel(btn_sel), .btn_step(btn_step),
    .mode_run(mode_run), .cpu_en(cpu_en_b), .seg(seg_b), .dp(dp_b), .an(an_b), .ch_idx(ch_idx_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input bit b, input int t, input logic [31:0] w, input int nd, input int ch, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      dsp_t d;
      int g;
      g = k % 8;
      d.t = t + 4 * k;
      d.an = ~(8'd1 << g);
      d.seg = (g < nd) ? GL[w[4*g +: 4]] : 7'h7F;
      d.dp = (g == ch) ? 1'b0 : 1'b1;
      if (b) qb.push_back(d);
      else qa.push_back(d);
    end
  endtask

  task automatic press_sel(input int v);
    ev_t ev;
    step(1);
    ev.t = cyc + 12;
    ev.v = v;
    qch.push_back(ev);
    btn_sel = 1'b1;
    step(20);
    btn_sel = 1'b0;
    step(20);
  endtask

  task automatic press_step(input int hold);
    step(1);
    qen.push_back(cyc + 12);
    btn_step = 1'b1;
    step(hold);
    btn_step = 1'b0;
    step(20);
  endtask

  task automatic check_reset();
    chk("rst_cpu_en", 32'(cpu_en), 0);
    chk("rst_an", 32'(an_a), 32'hFF);
    chk("rst_seg", 32'(seg_a), 32'h7F);
    chk("rst_dp", 32'(dp_a), 1);
    chk("rst_ch_idx", 32'(ch_idx), 0);
    chk("rst_an_b", 32'(an_b), 32'hFF);
  endtask

  always @(negedge clk) begin
    if (ch_idx !== last_ch) begin
      chk("ch_idx_expected", 32'(qch.size() > 0), 1);
      if (qch.size() > 0) begin
        ev_t ev;
        ev = qch.pop_front();
        chk("ch_idx_value", 32'(ch_idx), ev.v);
        if (ev.t >= 0) chk("ch_idx_cycle", cyc, ev.t);
      end
    end
    last_ch = ch_idx;
    if (cpu_en === 1'b1) begin
      chk("cpu_en_expected", 32'(qen.size() > 0), 1);
      if (qen.size() > 0) chk("cpu_en_cycle", cyc, qen.pop_front());
    end
    if ({an_a, seg_a, dp_a} !== last_a) begin
      if (mon_a) begin
        chk("dispA_expected", 32'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          dsp_t d;
          d = qa.pop_front();
          chk("dispA_an", 32'(an_a), 32'(d.an));
          chk("dispA_seg", 32'(seg_a), 32'(d.seg));
          chk("dispA_dp", 32'(dp_a), 32'(d.dp));
          chk("dispA_cycle", cyc, d.t);
        end
      end
      last_a = {an_a, seg_a, dp_a};
    end
    if ({an_b, seg_b, dp_b} !== last_b) begin
      if (mon_b) begin
        chk("dispB_expected", 32'(qb.size() > 0), 1);
        if (qb.size() > 0) begin
          dsp_t d;
          d = qb.pop_front();
          chk("dispB_an", 32'(an_b), 32'(d.an));
          chk("dispB_seg", 32'(seg_b), 32'(d.seg));
          chk("dispB_dp", 32'(dp_b), 32'(d.dp));
          chk("dispB_cycle", cyc, d.t);
        end
      end
      last_b = {an_b, seg_b, dp_b};
    end
  end

  initial begin
    ev_t ev;
    rst = 1'b1;
    btn_sel = 1'b0;
    btn_step = 1'b0;
    mode_run = 1'b0;
    ch_a = {32'h13579BDF, 32'hFEDCBA98, 32'h01234567, 32'h89ABCDEF};
    ch_b = {16'hA5C3, 16'h3333, 16'h2222, 16'h1111};
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset();
    // scan: full frame of channel 0 plus the wrap back to digit 0
    @(negedge clk);
    r = cyc;
    push_frame(0, r + 1, 32'h89ABCDEF, 8, 0, 9);
    mon_a = 1;
    rst = 1'b0;
    wait_cyc(r + 34);
    mon_a = 0;
    // debounce: short bounces must not move ch_idx
    for (int i = 0; i < 3; i++) begin
      btn_sel = 1'b1;
      step(5);
      btn_sel = 1'b0;
      step(5);
    end
    step(15);
    press_sel(1);
    press_sel(2);
    press_sel(3);
    press_sel(0);
    press_sel(1);
    press_sel(2);
    press_sel(3);
    // blanking on the 16-bit instance, aligned to the next frame start
    t0 = r + 1 + 32 * ((cyc + 6 - (r + 1) + 31) / 32);
    push_frame(1, t0, 32'h0000A5C3, 4, 3, 8);
    wait_cyc(t0 - 2);
    mon_b = 1;
    wait_cyc(t0 + 31);
    mon_b = 0;
    // run mode with an ignored step press, then toggle off and on
    step(1);
    c = cyc;
    for (int k = 0; k < 5; k++) qen.push_back(c + 12 + 10 * k);
    mode_run = 1'b1;
    step(15);
    btn_step = 1'b1;
    step(15);
    btn_step = 1'b0;
    wait_cyc(c + 55);
    mode_run = 1'b0;
    step(10);
    e = cyc;
    qen.push_back(e + 12);
    qen.push_back(e + 22);
    mode_run = 1'b1;
    wait_cyc(e + 25);
    mode_run = 1'b0;
    step(20);
    // step mode: three clean presses, then one long hold
    press_step(20);
    press_step(20);
    press_step(20);
    press_step(100);
    // mid-operation reset with ch_idx=2 while cpu_en is high
    press_sel(0);
    press_sel(1);
    press_sel(2);
    step(1);
    c = cyc;
    qen.push_back(c + 12);
    mode_run = 1'b1;
    wait_cyc(c + 12);
    @(negedge clk);
    #1;
    ev.t = -1;
    ev.v = 0;
    qch.push_back(ev);
    rst = 1'b1;
    mode_run = 1'b0;
    #1;
    check_reset();
    step(3);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_an", 32'(an_a), 32'hFE);
    chk("post_rst_seg", 32'(seg_a), 32'(GL[15]));
    chk("post_rst_dp", 32'(dp_a), 0);
    chk("post_rst_an_b", 32'(an_b), 32'hFE);
    step(20);
    chk("ch_queue_drained", qch.size(), 0);
    chk("cpu_en_queue_drained", qen.size(), 0);
    chk("dispA_queue_drained", qa.size(), 0);
    chk("dispB_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
